// File: rtl/traffic_sensor_frontend_pkg.sv
// Shared constants and types for the traffic sensor front end.
// Road indices, density codes, emergency FSM states, defaults.
package traffic_sensor_frontend_pkg;

  localparam logic [1:0] ROAD_A = 2'd0;
  localparam logic [1:0] ROAD_B = 2'd1;
  localparam logic [1:0] ROAD_C = 2'd2;
  localparam logic [1:0] ROAD_D = 2'd3;

  localparam logic [1:0] DENS_NONE = 2'd0;
  localparam logic [1:0] DENS_LOW  = 2'd1;
  localparam logic [1:0] DENS_MED  = 2'd2;
  localparam logic [1:0] DENS_HIGH = 2'd3;

  typedef enum logic [1:0] {
    E_IDLE,
    E_LOCK,
    E_HOLD
  } emg_state_e;

  localparam int DEF_DEBOUNCE = 4;
  localparam int DEF_WINDOW   = 200;
  localparam int DEF_TH1      = 2;
  localparam int DEF_TH2      = 5;
  localparam int DEF_TH3      = 9;
  localparam int DEF_PRES     = 20;
  localparam int DEF_EMG      = 50;

  // Fixed priority: road A wins over B, B over C, C over D.
  function automatic logic [1:0] lowest_road(
    input logic [3:0] s
  );
    logic [1:0] r;
    r = ROAD_A;
    if (s[0])      r = ROAD_A;
    else if (s[1]) r = ROAD_B;
    else if (s[2]) r = ROAD_C;
    else if (s[3]) r = ROAD_D;
    return r;
  endfunction

  // Map an arrival count onto the 2-bit density scale.
  function automatic logic [1:0] density_code(
    input logic [7:0] c,
    input int         th1,
    input int         th2,
    input int         th3
  );
    int cv;
    logic [1:0] d;
    cv = int'(c);
    if (cv >= th3)      d = DENS_HIGH;
    else if (cv >= th2) d = DENS_MED;
    else if (cv >= th1) d = DENS_LOW;
    else                d = DENS_NONE;
    return d;
  endfunction

endpackage

// File: rtl/traffic_sensor_frontend_filter.sv
// Two-flop synchroniser plus run-length debounce for one raw line.
// rise/fall flag the cycle whose closing edge flips the level.
module input_debounce_filter
  import traffic_sensor_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int RW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_d;
  logic          flip;

  // Count consecutive disagreeing samples; flip on the last one.
  always_comb begin
    run_d   = '0;
    level_d = level_q;
    flip    = 1'b0;
    if (sync2_q != level_q) begin
      if (run_q == RW'(DEBOUNCE_CYCLES - 1)) begin
        flip    = 1'b1;
        level_d = ~level_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  // Synchroniser, run counter and filtered level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      run_q   <= run_d;
    end
  end

  assign level = level_q;
  assign rise  = flip & ~level_q;
  assign fall  = flip & level_q;

endmodule

// File: rtl/traffic_sensor_frontend.sv
// Per-road density/presence and siren arbitration front end.
// Eight filtered lines feed window counters and a lock-and-hold FSM.
module traffic_sensor_frontend
  import traffic_sensor_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int WINDOW_CYCLES   = DEF_WINDOW,
  parameter int TH1             = DEF_TH1,
  parameter int TH2             = DEF_TH2,
  parameter int TH3             = DEF_TH3,
  parameter int PRESENCE_HOLD   = DEF_PRES,
  parameter int EMG_HOLD        = DEF_EMG
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       loop_a,
  input  logic       loop_b,
  input  logic       loop_c,
  input  logic       loop_d,
  input  logic       siren_a,
  input  logic       siren_b,
  input  logic       siren_c,
  input  logic       siren_d,
  output logic [1:0] TA,
  output logic [1:0] TB,
  output logic [1:0] TC,
  output logic [1:0] TD,
  output logic       VA,
  output logic       VB,
  output logic       VC,
  output logic       VD,
  output logic       emg_mode,
  output logic [1:0] ER,
  output logic       window_tick
);

  localparam int WW = (WINDOW_CYCLES > 1) ?
                      $clog2(WINDOW_CYCLES) : 1;
  localparam int PW = $clog2(PRESENCE_HOLD + 1);
  localparam int EW = $clog2(EMG_HOLD + 1);

  logic [3:0] loop_raw;
  logic [3:0] sir_raw;
  logic [3:0] loop_lvl;
  logic [3:0] loop_rise;
  logic [3:0] loop_fall;
  logic [3:0] sir_lvl;
  logic [3:0] sir_rise;
  logic [3:0] sir_fall;

  assign loop_raw = {loop_d, loop_c, loop_b, loop_a};
  assign sir_raw  = {siren_d, siren_c, siren_b, siren_a};

  for (genvar i = 0; i < 4; i++) begin : g_loop
    input_debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_loop (
      .clk   (clk),
      .rst   (rst),
      .raw_in(loop_raw[i]),
      .level (loop_lvl[i]),
      .rise  (loop_rise[i]),
      .fall  (loop_fall[i])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_siren
    input_debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_siren (
      .clk   (clk),
      .rst   (rst),
      .raw_in(sir_raw[i]),
      .level (sir_lvl[i]),
      .rise  (sir_rise[i]),
      .fall  (sir_fall[i])
    );
  end

  logic [WW-1:0] win_q;
  logic [WW-1:0] win_d;
  logic          tick;

  assign tick = (win_q == WW'(WINDOW_CYCLES - 1));

  // Free-running window counter; wraps after the tick cycle.
  always_comb begin
    win_d = win_q + 1'b1;
    if (tick) win_d = '0;
  end

  logic [7:0]    cnt_q  [4];
  logic [7:0]    cnt_d  [4];
  logic [1:0]    dens_q [4];
  logic [1:0]    dens_d [4];
  logic [PW-1:0] hold_q [4];
  logic [PW-1:0] hold_d [4];

  // Per-road arrival count, density latch and presence hold.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]  = cnt_q[i];
      dens_d[i] = dens_q[i];
      hold_d[i] = hold_q[i];
      if (tick) begin
        dens_d[i] = density_code(cnt_q[i], TH1, TH2, TH3);
        cnt_d[i]  = {7'd0, loop_rise[i]};
      end else if (loop_rise[i] && cnt_q[i] != 8'hFF) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
      if (loop_rise[i]) begin
        hold_d[i] = '0;
      end else if (loop_fall[i]) begin
        hold_d[i] = PW'(PRESENCE_HOLD);
      end else if (hold_q[i] != '0) begin
        hold_d[i] = hold_q[i] - 1'b1;
      end
    end
  end

  emg_state_e    state_q;
  emg_state_e    state_d;
  logic          emg_q;
  logic          emg_d;
  logic [1:0]    er_q;
  logic [1:0]    er_d;
  logic [EW-1:0] ehold_q;
  logic [EW-1:0] ehold_d;

  // Emergency arbitration: lock lowest road, hold after release.
  always_comb begin
    state_d = state_q;
    emg_d   = emg_q;
    er_d    = er_q;
    ehold_d = ehold_q;
    unique case (state_q)
      E_IDLE: begin
        emg_d = 1'b0;
        if (|sir_lvl) begin
          state_d = E_LOCK;
          er_d    = lowest_road(sir_lvl);
          emg_d   = 1'b1;
        end
      end
      E_LOCK: begin
        if (sir_fall[er_q]) begin
          state_d = E_HOLD;
          ehold_d = EW'(EMG_HOLD);
        end
      end
      E_HOLD: begin
        if (sir_rise[er_q]) begin
          state_d = E_LOCK;
        end else if (ehold_q == '0) begin
          if (|sir_lvl) begin
            state_d = E_LOCK;
            er_d    = lowest_road(sir_lvl);
          end else begin
            state_d = E_IDLE;
            emg_d   = 1'b0;
          end
        end else begin
          ehold_d = ehold_q - 1'b1;
        end
      end
      default: begin
        state_d = E_IDLE;
        emg_d   = 1'b0;
      end
    endcase
  end

  // All block state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      state_q <= E_IDLE;
      emg_q   <= 1'b0;
      er_q    <= 2'd0;
      ehold_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= 8'd0;
        dens_q[i] <= DENS_NONE;
        hold_q[i] <= '0;
      end
    end else begin
      win_q   <= win_d;
      state_q <= state_d;
      emg_q   <= emg_d;
      er_q    <= er_d;
      ehold_q <= ehold_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= cnt_d[i];
        dens_q[i] <= dens_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign TA = dens_q[0];
  assign TB = dens_q[1];
  assign TC = dens_q[2];
  assign TD = dens_q[3];

  assign VA = loop_lvl[0] | (hold_q[0] != '0);
  assign VB = loop_lvl[1] | (hold_q[1] != '0);
  assign VC = loop_lvl[2] | (hold_q[2] != '0);
  assign VD = loop_lvl[3] | (hold_q[3] != '0);

  assign emg_mode    = emg_q;
  assign ER          = er_q;
  assign window_tick = tick;

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Directed bench for traffic_sensor_frontend.
// Second instance with a long window covers counter saturation.
module tb_traffic_sensor_frontend;
  import traffic_sensor_frontend_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] lp;
  logic [3:0] sr;

  logic [1:0] TA, TB, TC, TD, ER;
  logic       VA, VB, VC, VD, emg_mode, window_tick;
  logic [1:0] s_TA, s_TB, s_TC, s_TD, s_ER;
  logic       s_VA, s_VB, s_VC, s_VD, s_emg, s_tick;

  int total;
  int bad;
  int cyc;

  traffic_sensor_frontend dut (
    .clk(clk), .rst(rst),
    .loop_a(lp[0]), .loop_b(lp[1]),
    .loop_c(lp[2]), .loop_d(lp[3]),
    .siren_a(sr[0]), .siren_b(sr[1]),
    .siren_c(sr[2]), .siren_d(sr[3]),
    .TA(TA), .TB(TB), .TC(TC), .TD(TD),
    .VA(VA), .VB(VB), .VC(VC), .VD(VD),
    .emg_mode(emg_mode), .ER(ER),
    .window_tick(window_tick)
  );

  traffic_sensor_frontend #(
    .WINDOW_CYCLES(4000)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .loop_a(lp[0]), .loop_b(lp[1]),
    .loop_c(lp[2]), .loop_d(lp[3]),
    .siren_a(sr[0]), .siren_b(sr[1]),
    .siren_c(sr[2]), .siren_d(sr[3]),
    .TA(s_TA), .TB(s_TB), .TC(s_TC), .TD(s_TD),
    .VA(s_VA), .VB(s_VB), .VC(s_VC), .VD(s_VD),
    .emg_mode(s_emg), .ER(s_ER),
    .window_tick(s_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_phase(input int m, input int ph);
    int g;
    g = 0;
    while ((cyc % m) != ph && g < 2 * m + 10) begin
      step(1);
      g++;
    end
    if ((cyc % m) != ph) begin
      total++;
      bad++;
      $display("FAIL wait_phase got=%0d want=%0d",
               cyc % m, ph);
    end
  endtask

  task automatic pulse_b(input int n);
    for (int k = 0; k < n; k++) begin
      lp[1] = 1'b1;
      step(8);
      lp[1] = 1'b0;
      step(8);
    end
  endtask

  task automatic test_reset;
    lp  = 4'hF;
    sr  = 4'hF;
    rst = 1'b1;
    step(3);
    total++;
    if ({TA, TB, TC, TD, VA, VB, VC, VD,
         emg_mode, ER, window_tick} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outs got=%h want=0",
               {TA, TB, TC, TD, VA, VB, VC, VD,
                emg_mode, ER, window_tick});
    end
    rst = 1'b0;
    step(5);
    total++;
    if ({VA, VB, VC, VD} !== 4'b0000) begin
      bad++;
      $display("FAIL v_early got=%b want=0000",
               {VA, VB, VC, VD});
    end
    step(1);
    total++;
    if ({VA, VB, VC, VD} !== 4'b1111) begin
      bad++;
      $display("FAIL v_rise got=%b want=1111",
               {VA, VB, VC, VD});
    end
    lp = 4'h0;
    sr = 4'h0;
    step(100);
    total++;
    if (emg_mode !== 1'b0) begin
      bad++;
      $display("FAIL emg_settle got=%b want=0", emg_mode);
    end
  endtask

  task automatic test_window;
    wait_phase(200, 198);
    total++;
    if (window_tick !== 1'b0) begin
      bad++;
      $display("FAIL tick_198 got=%b want=0", window_tick);
    end
    step(1);
    total++;
    if (window_tick !== 1'b1) begin
      bad++;
      $display("FAIL tick_199 got=%b want=1", window_tick);
    end
    step(1);
    total++;
    if (window_tick !== 1'b0) begin
      bad++;
      $display("FAIL tick_0 got=%b want=0", window_tick);
    end
  endtask

  task automatic test_debounce;
    logic [7:0] c0;
    logic       ok;
    c0 = dut.cnt_q[0];
    lp[0] = 1'b1;
    step(3);
    lp[0] = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      step(1);
      if (VA !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL glitch_va got=1 want=0");
    end
    total++;
    if (dut.cnt_q[0] !== c0) begin
      bad++;
      $display("FAIL glitch_cnt got=%0d want=%0d",
               dut.cnt_q[0], c0);
    end
    lp[0] = 1'b1;
    step(5);
    total++;
    if (VA !== 1'b0) begin
      bad++;
      $display("FAIL va_pre got=%b want=0", VA);
    end
    step(1);
    total++;
    if (VA !== 1'b1) begin
      bad++;
      $display("FAIL va_rise got=%b want=1", VA);
    end
    step(4);
    lp[0] = 1'b0;
    step(25);
    total++;
    if (VA !== 1'b1) begin
      bad++;
      $display("FAIL va_hold got=%b want=1", VA);
    end
    step(1);
    total++;
    if (VA !== 1'b0) begin
      bad++;
      $display("FAIL va_fall got=%b want=0", VA);
    end
    total++;
    if (dut.cnt_q[0] !== c0 + 8'd1) begin
      bad++;
      $display("FAIL arr_cnt got=%0d want=%0d",
               dut.cnt_q[0], c0 + 8'd1);
    end
  endtask

  task automatic test_density;
    wait_phase(200, 0);
    pulse_b(5);
    wait_phase(200, 0);
    total++;
    if (TB !== 2'd2) begin
      bad++;
      $display("FAIL dens5 got=%0d want=2", TB);
    end
    pulse_b(9);
    wait_phase(200, 199);
    total++;
    if (TB !== 2'd2) begin
      bad++;
      $display("FAIL dens_hold got=%0d want=2", TB);
    end
    step(1);
    total++;
    if (TB !== 2'd3) begin
      bad++;
      $display("FAIL dens9 got=%0d want=3", TB);
    end
    step(1);
    wait_phase(200, 0);
    total++;
    if (TB !== 2'd0) begin
      bad++;
      $display("FAIL dens0 got=%0d want=0", TB);
    end
  endtask

  task automatic test_tick_arrival;
    pulse_b(1);
    wait_phase(200, 194);
    lp[1] = 1'b1;
    step(6);
    total++;
    if (TB !== 2'd0) begin
      bad++;
      $display("FAIL tick_arr_old got=%0d want=0", TB);
    end
    total++;
    if (dut.cnt_q[1] !== 8'd1) begin
      bad++;
      $display("FAIL tick_arr_cnt got=%0d want=1",
               dut.cnt_q[1]);
    end
    step(2);
    lp[1] = 1'b0;
    step(8);
    pulse_b(1);
    wait_phase(200, 0);
    total++;
    if (TB !== 2'd1) begin
      bad++;
      $display("FAIL tick_arr_new got=%0d want=1", TB);
    end
  endtask

  task automatic test_emergency;
    sr[2] = 1'b1;
    sr[1] = 1'b1;
    step(6);
    total++;
    if (emg_mode !== 1'b0) begin
      bad++;
      $display("FAIL emg_pre got=%b want=0", emg_mode);
    end
    step(1);
    total++;
    if (emg_mode !== 1'b1 || ER !== 2'b01) begin
      bad++;
      $display("FAIL emg_lock got=%b/%b want=1/01",
               emg_mode, ER);
    end
    step(3);
    sr[0] = 1'b1;
    step(10);
    total++;
    if (ER !== 2'b01) begin
      bad++;
      $display("FAIL er_frozen got=%b want=01", ER);
    end
    sr[1] = 1'b0;
    step(56);
    total++;
    if (emg_mode !== 1'b1 || ER !== 2'b01) begin
      bad++;
      $display("FAIL emg_hold got=%b/%b want=1/01",
               emg_mode, ER);
    end
    step(1);
    total++;
    if (emg_mode !== 1'b1 || ER !== 2'b00) begin
      bad++;
      $display("FAIL er_relock got=%b/%b want=1/00",
               emg_mode, ER);
    end
    sr[0] = 1'b0;
    sr[2] = 1'b0;
    step(56);
    total++;
    if (emg_mode !== 1'b1 || ER !== 2'b00) begin
      bad++;
      $display("FAIL emg_hold2 got=%b/%b want=1/00",
               emg_mode, ER);
    end
    step(1);
    total++;
    if (emg_mode !== 1'b0 || ER !== 2'b00) begin
      bad++;
      $display("FAIL emg_idle got=%b/%b want=0/00",
               emg_mode, ER);
    end
  endtask

  task automatic test_hold_cancel;
    logic ok;
    sr[3] = 1'b1;
    step(7);
    total++;
    if (emg_mode !== 1'b1 || ER !== 2'b11) begin
      bad++;
      $display("FAIL d_lock got=%b/%b want=1/11",
               emg_mode, ER);
    end
    step(3);
    sr[3] = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      step(1);
      if (emg_mode !== 1'b1) ok = 1'b0;
    end
    sr[3] = 1'b1;
    repeat (5) begin
      step(1);
      if (emg_mode !== 1'b1) ok = 1'b0;
    end
    total++;
    if (dut.state_q !== E_HOLD) begin
      bad++;
      $display("FAIL in_hold got=%0d want=%0d",
               dut.state_q, E_HOLD);
    end
    step(1);
    total++;
    if (dut.state_q !== E_LOCK || ER !== 2'b11 ||
        emg_mode !== 1'b1 || !ok) begin
      bad++;
      $display("FAIL cancel got=%0d/%b/%b/%b want=%0d/11/1/1",
               dut.state_q, ER, emg_mode, ok, E_LOCK);
    end
    sr[3] = 1'b0;
    step(70);
    total++;
    if (emg_mode !== 1'b0 || ER !== 2'b11) begin
      bad++;
      $display("FAIL idle_er got=%b/%b want=0/11",
               emg_mode, ER);
    end
  endtask

  task automatic test_saturation;
    wait_phase(4000, 0);
    for (int k = 0; k < 300; k++) begin
      lp[2] = 1'b1;
      step(6);
      lp[2] = 1'b0;
      step(6);
    end
    wait_phase(4000, 3999);
    total++;
    if (dut_sat.cnt_q[2] !== 8'd255) begin
      bad++;
      $display("FAIL sat_cnt got=%0d want=255",
               dut_sat.cnt_q[2]);
    end
    step(1);
    total++;
    if (s_TC !== 2'd3) begin
      bad++;
      $display("FAIL sat_tc got=%0d want=3", s_TC);
    end
  endtask

  task automatic test_mid_reset;
    sr[0] = 1'b1;
    step(8);
    total++;
    if (emg_mode !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst got=%b want=1", emg_mode);
    end
    rst = 1'b1;
    step(1);
    total++;
    if (emg_mode !== 1'b0 || ER !== 2'b00 ||
        window_tick !== 1'b0 || TB !== 2'd0 ||
        dut.state_q !== E_IDLE) begin
      bad++;
      $display("FAIL mid_rst got=%b/%b/%b/%0d want=0/00/0/0",
               emg_mode, ER, window_tick, TB);
    end
    rst = 1'b0;
    sr[0] = 1'b0;
    step(198);
    total++;
    if (window_tick !== 1'b0) begin
      bad++;
      $display("FAIL rst_win198 got=%b want=0",
               window_tick);
    end
    step(1);
    total++;
    if (window_tick !== 1'b1 || emg_mode !== 1'b0) begin
      bad++;
      $display("FAIL rst_win199 got=%b/%b want=1/0",
               window_tick, emg_mode);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    lp    = 4'h0;
    sr    = 4'h0;
    test_reset();
    test_window();
    test_debounce();
    test_density();
    test_tick_arrival();
    test_emergency();
    test_hold_cancel();
    test_saturation();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
